// File: rtl/alu_unit_if.sv
// Request/response bundle of the sequential ALU. The tri-state data bus stays
// a plain port on alu_unit so the output-enable driver sits at the module boundary.
interface alu_unit_if #(parameter int N = 8);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_en;
  logic [N-1:0] result;
  logic         busy;
  logic         done;
  logic         flag_z;
  logic         flag_c;
  logic         flag_n;

  modport master (output start, op, a, b, out_en,
                  input  result, busy, done, flag_z, flag_c, flag_n);
  modport slave  (input  start, op, a, b, out_en,
                  output result, busy, done, flag_z, flag_c, flag_n);
endinterface

// File: rtl/alu_unit.sv
// Sequential N-bit ALU fed by register-file taps r0/r1, result driven onto the
// shared bus through an output enable. Define ALU_MUL_EN to build the shift-add multiplier.
module alu_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_unit_if.slave    bus,
  output wire [N-1:0]  data_out
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic [N-1:0] result_q;
  logic         z_q, c_q, n_q;
  logic         capture;

  logic [N-1:0] alu_r;
  logic         alu_c;

`ifdef ALU_MUL_EN
  logic [2*N-1:0] acc_q, mcand_q, acc_nxt;
  logic [CW-1:0]  cnt_q;
  logic           mul_last;

  assign acc_nxt  = acc_q + (b_q[0] ? mcand_q : {2*N{1'b0}});
  assign mul_last = (cnt_q == CW'(N-1));
`endif

  assign capture = (state_q == S_IDLE) && bus.start;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
`ifdef ALU_MUL_EN
        state_d = (bus.op == 3'b111) ? S_MUL : S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: state_d = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:  if (mul_last) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  // single-cycle datapath; opcode 111 lands here only when the multiplier is absent
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (op_q)
      3'b000: {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
      3'b001: {alu_c, alu_r} = {1'b0, a_q} - {1'b0, b_q};
      3'b010: alu_r = a_q & b_q;
      3'b011: alu_r = a_q | b_q;
      3'b100: alu_r = a_q ^ b_q;
      3'b101: begin alu_r = {a_q[N-2:0], 1'b0}; alu_c = a_q[N-1]; end
      3'b110: begin alu_r = {1'b0, a_q[N-1:1]}; alu_c = a_q[0]; end
      default: begin alu_r = '0; alu_c = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      if (capture) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.op;
`ifdef ALU_MUL_EN
        acc_q   <= '0;
        mcand_q <= {{N{1'b0}}, bus.a};
        cnt_q   <= '0;
`endif
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_r;
        c_q      <= alu_c;
        z_q      <= (alu_r == '0);
        n_q      <= alu_r[N-1];
      end
`ifdef ALU_MUL_EN
      // b_q doubles as the multiplier shift register, consumed LSB first
      if (state_q == S_MUL) begin
        acc_q   <= acc_nxt;
        mcand_q <= mcand_q << 1;
        b_q     <= b_q >> 1;
        cnt_q   <= cnt_q + CW'(1);
        if (mul_last) begin
          result_q <= acc_nxt[N-1:0];
          c_q      <= |acc_nxt[2*N-1:N];
          z_q      <= (acc_nxt[N-1:0] == '0);
          n_q      <= acc_nxt[N-1];
        end
      end
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.flag_z = z_q;
  assign bus.flag_c = c_q;
  assign bus.flag_n = n_q;
  assign data_out   = bus.out_en ? result_q : {N{1'bz}};

endmodule
